// File: rtl/constraint_sample_driver_if.sv
// Handshake and data bundle between the sample driver, its request controller,
// the external constraint checker and the sample consumer.
interface constraint_sample_driver_if #(
    parameter int unsigned VEC_W = 64,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             seed_load;
    logic [31:0]      seed_in;
    logic [VEC_W-1:0] cand_out;
    logic             chk_sat;
    logic             sample_valid;
    logic             sample_ready;
    logic [VEC_W-1:0] sample_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] accepted_count;

    // Environment side: controller, checker and consumer.
    modport master (
        output start, n_samples, seed_load, seed_in, chk_sat, sample_ready,
        input  cand_out, sample_valid, sample_data, busy, done, timeout, accepted_count
    );

    // Driver side.
    modport slave (
        input  start, n_samples, seed_load, seed_in, chk_sat, sample_ready,
        output cand_out, sample_valid, sample_data, busy, done, timeout, accepted_count
    );
endinterface

// File: rtl/constraint_sample_driver.sv
// Generates xorshift candidates, drives them to an external combinational
// checker and streams out only the candidates the checker accepts.
module constraint_sample_driver #(
    parameter int unsigned VEC_W     = 64,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter int unsigned MAX_TRIES = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input logic                       clk,
    input logic                       rst,
    constraint_sample_driver_if.slave bus
);
    localparam int unsigned W      = (VEC_W + 31) / 32;
    localparam int unsigned WIDE_W = W * 32;
    localparam int unsigned WIDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

    localparam logic [31:0]       SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(W - 1);
    localparam logic [TRY_W-1:0]  TRY_LIMIT = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {StIdle, StFill, StCheck, StHold} state_e;

    function automatic logic [31:0] xorshift_next(input logic [31:0] r);
        logic [31:0] x;
        x = r ^ (r << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    state_e            state_q, state_d;
    logic [31:0]       rng_q, rng_d;
    logic [VEC_W-1:0]  cand_q, cand_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic [WIDE_W-1:0] fill_wide;
    logic [WIDE_W-1:0] word_mask;
    logic [TRY_W-1:0]  tries_inc;
    logic [CNT_W-1:0]  acc_inc;

    // Next-state logic for the request FSM and all registered outputs.
    always_comb begin
        state_d   = state_q;
        rng_d     = rng_q;
        cand_d    = cand_q;
        widx_d    = widx_q;
        tries_d   = tries_q;
        n_d       = n_q;
        acc_d     = acc_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        // Current generator word replicated into every slot; the mask picks the slot.
        fill_wide = {W{rng_q}};
        word_mask = WIDE_W'(32'hFFFF_FFFF) << (32 * 32'(widx_q));
        tries_inc = (tries_q == TRY_LIMIT) ? tries_q : tries_q + 1'b1;
        acc_inc   = acc_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                // Seed load takes effect before a same-cycle start fills.
                if (bus.seed_load) begin
                    rng_d = (bus.seed_in == 32'd0) ? 32'd1 : bus.seed_in;
                end
                if (bus.start) begin
                    if (bus.n_samples == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d       = bus.n_samples;
                        timeout_d = 1'b0;
                        acc_d     = '0;
                        tries_d   = '0;
                        widx_d    = '0;
                        state_d   = StFill;
                    end
                end
            end
            StFill: begin
                cand_d = (cand_q & ~word_mask[VEC_W-1:0])
                       | (fill_wide[VEC_W-1:0] & word_mask[VEC_W-1:0]);
                rng_d  = xorshift_next(rng_q);
                if (widx_q == LAST_WORD) begin
                    widx_d  = '0;
                    state_d = StCheck;
                end else begin
                    widx_d = widx_q + 1'b1;
                end
            end
            StCheck: begin
                tries_d = tries_inc;
                if (bus.chk_sat) begin
                    valid_d = 1'b1;
                    state_d = StHold;
                end else if (tries_inc == TRY_LIMIT) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    state_d = StFill;
                end
            end
            StHold: begin
                if (bus.sample_ready) begin
                    valid_d = 1'b0;
                    acc_d   = acc_inc;
                    tries_d = '0;
                    if (acc_inc == n_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; a reset abandons any request silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rng_q     <= SEED_INIT;
            cand_q    <= '0;
            widx_q    <= '0;
            tries_q   <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rng_q     <= rng_d;
            cand_q    <= cand_d;
            widx_q    <= widx_d;
            tries_q   <= tries_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.cand_out       = cand_q;
    assign bus.sample_data    = cand_q;
    assign bus.sample_valid   = valid_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.done           = done_q;
    assign bus.timeout        = timeout_q;
    assign bus.accepted_count = acc_q;
endmodule

// File: tb/tb_constraint_sample_driver.sv
// Self-checking bench: a 32-bit driver (short timeout) and a 64-bit driver,
// with expected samples queued from a bench-side xorshift model.
module tb_constraint_sample_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_a, exp_b;
    logic [31:0] model_rng;
    int          mode_a;

    constraint_sample_driver_if #(.VEC_W(32), .CNT_W(16)) if_a ();
    constraint_sample_driver_if #(.VEC_W(64), .CNT_W(16)) if_b ();

    // Checker stubs: 0 always satisfied, 1 only 0x00042021, 2 never.
    assign if_a.chk_sat = (mode_a == 0) ? 1'b1 :
                          (mode_a == 1) ? (if_a.cand_out == 32'h0004_2021) : 1'b0;
    assign if_b.chk_sat = 1'b1;

    constraint_sample_driver #(.VEC_W(32), .SEED(32'h1), .MAX_TRIES(4), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );
    constraint_sample_driver #(.VEC_W(64), .SEED(32'h1), .MAX_TRIES(4), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    function automatic logic [31:0] xs_next(input logic [31:0] r);
        logic [31:0] x;
        x = r ^ (r << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    // Scoreboard: every handoff pops the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && if_a.sample_valid && if_a.sample_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL handoff_a: got 0x%08h, required no handoff", if_a.sample_data);
            end else begin
                exp_a = exp_q.pop_front();
                if ({32'h0, if_a.sample_data} !== exp_a) begin
                    n_fail++;
                    $display("FAIL handoff_a: got 0x%08h, required 0x%08h",
                             if_a.sample_data, exp_a[31:0]);
                end
            end
        end
        if (!rst && if_b.sample_valid && if_b.sample_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL handoff_b: got 0x%016h, required no handoff", if_b.sample_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (if_b.sample_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL handoff_b: got 0x%016h, required 0x%016h",
                             if_b.sample_data, exp_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a();
        exp_q.push_back({32'h0, model_rng});
        model_rng = xs_next(model_rng);
    endtask

    task automatic do_reset();
        if_a.start = 1'b0; if_a.seed_load = 1'b0; if_a.sample_ready = 1'b0;
        if_b.start = 1'b0; if_b.seed_load = 1'b0; if_b.sample_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rng = 32'h1;
    endtask

    task automatic start_a(input logic [15:0] n);
        if_a.n_samples = n;
        if_a.start     = 1'b1;
        tick();
        if_a.start = 1'b0;
    endtask

    // Flags are {sample_valid, done, busy, timeout}.
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({if_a.cand_out, if_a.sample_valid, if_a.done, if_a.busy, if_a.timeout,
             if_a.accepted_count} !== 52'h0) begin
            n_fail++;
            $display("FAIL reset_a: got cand=%h flags=%b%b%b%b acc=%0d, required all zero",
                     if_a.cand_out, if_a.sample_valid, if_a.done, if_a.busy, if_a.timeout,
                     if_a.accepted_count);
        end
        n_tests++;
        if ({if_b.cand_out, if_b.sample_valid, if_b.done, if_b.busy, if_b.timeout,
             if_b.accepted_count} !== 84'h0) begin
            n_fail++;
            $display("FAIL reset_b: got cand=%h flags=%b%b%b%b acc=%0d, required all zero",
                     if_b.cand_out, if_b.sample_valid, if_b.done, if_b.busy, if_b.timeout,
                     if_b.accepted_count);
        end
        rst = 1'b0;
        model_rng = 32'h1;
    endtask

    task automatic test_one_word();
        logic [31:0] want [2];
        want[0] = 32'h0000_0001;
        want[1] = 32'h0004_2021;
        mode_a = 0;
        if_a.sample_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_a();
            start_a(16'd1);
            for (int c = 1; c <= 2; c++) begin
                n_tests++;
                if ({if_a.sample_valid, if_a.busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL one_word_r%0d_c%0d: valid/busy=%b%b, required 01",
                             r, c, if_a.sample_valid, if_a.busy);
                end
                tick();
            end
            n_tests++;
            if ({if_a.sample_valid, if_a.sample_data} !== {1'b1, want[r]}) begin
                n_fail++;
                $display("FAIL one_word_r%0d_c3: valid=%b data=0x%08h, required 1 0x%08h",
                         r, if_a.sample_valid, if_a.sample_data, want[r]);
            end
            tick();
            n_tests++;
            if ({if_a.sample_valid, if_a.done, if_a.busy, if_a.accepted_count} !==
                {3'b010, 16'd1}) begin
                n_fail++;
                $display("FAIL one_word_r%0d_done: valid/done/busy=%b%b%b acc=%0d, req 010 1",
                         r, if_a.sample_valid, if_a.done, if_a.busy, if_a.accepted_count);
            end
            tick();
            n_tests++;
            if (if_a.done !== 1'b0) begin
                n_fail++;
                $display("FAIL one_word_r%0d_pulse: done=%b, required 0", r, if_a.done);
            end
        end
    endtask

    task automatic test_reject();
        logic [31:0] cand;
        int          tries;
        do_reset();
        mode_a = 1;
        if_a.sample_ready = 1'b1;
        tries = 0;
        do begin
            cand      = model_rng;
            model_rng = xs_next(model_rng);
            tries++;
        end while (cand != 32'h0004_2021);
        exp_q.push_back({32'h0, cand});
        start_a(16'd1);
        // Each try costs one FILL and one CHECK cycle.
        for (int c = 1; c <= 2 * tries; c++) begin
            n_tests++;
            if ({if_a.sample_valid, if_a.busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL reject_c%0d: valid/busy=%b%b, required 01",
                         c, if_a.sample_valid, if_a.busy);
            end
            tick();
        end
        n_tests++;
        if ({if_a.sample_valid, if_a.timeout, if_a.sample_data} !== {2'b10, 32'h0004_2021}) begin
            n_fail++;
            $display("FAIL reject_hold: valid=%b timeout=%b data=0x%08h, required 1 0 0x00042021",
                     if_a.sample_valid, if_a.timeout, if_a.sample_data);
        end
        tick();
        n_tests++;
        if ({if_a.done, if_a.timeout, if_a.accepted_count} !== {2'b10, 16'd1}) begin
            n_fail++;
            $display("FAIL reject_done: done=%b timeout=%b acc=%0d, required 1 0 1",
                     if_a.done, if_a.timeout, if_a.accepted_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mode_a = 2;
        if_a.sample_ready = 1'b1;
        start_a(16'd3);
        // Four FILL/CHECK rounds, done in the cycle after the fourth CHECK.
        for (int c = 1; c <= 8; c++) begin
            n_tests++;
            if ({if_a.sample_valid, if_a.done, if_a.busy, if_a.timeout} !== 4'b0010) begin
                n_fail++;
                $display("FAIL timeout_c%0d: flags=%b%b%b%b, required 0010", c,
                         if_a.sample_valid, if_a.done, if_a.busy, if_a.timeout);
            end
            tick();
        end
        n_tests++;
        if ({if_a.sample_valid, if_a.done, if_a.busy, if_a.timeout, if_a.accepted_count} !==
            {4'b0101, 16'd0}) begin
            n_fail++;
            $display("FAIL timeout_fire: flags=%b%b%b%b acc=%0d, required 0101 0",
                     if_a.sample_valid, if_a.done, if_a.busy, if_a.timeout, if_a.accepted_count);
        end
        tick();
        n_tests++;
        if ({if_a.done, if_a.timeout} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_sticky: done=%b timeout=%b, required 0 1",
                     if_a.done, if_a.timeout);
        end
        start_a(16'd1);
        n_tests++;
        if ({if_a.busy, if_a.timeout} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_clear: busy=%b timeout=%b, required 1 0",
                     if_a.busy, if_a.timeout);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [63:0] e0, e1;
        r  = 32'h1;
        e0[31:0] = r;  r = xs_next(r);
        e0[63:32] = r; r = xs_next(r);
        e1[31:0] = r;  r = xs_next(r);
        e1[63:32] = r;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        if_b.sample_ready = 1'b0;
        if_b.n_samples    = 16'd2;
        if_b.start        = 1'b1;
        tick();
        if_b.start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_tests++;
            if (if_b.sample_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_fill_c%0d: valid=%b, required 0", c, if_b.sample_valid);
            end
            tick();
        end
        n_tests++;
        if ({if_b.sample_valid, if_b.cand_out} !== {1'b1, 32'h0004_2021, 32'h0000_0001}) begin
            n_fail++;
            $display("FAIL b2b_words: valid=%b cand=0x%016h, required 1 0x0004202100000001",
                     if_b.sample_valid, if_b.cand_out);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if ({if_b.sample_valid, if_b.done, if_b.sample_data} !== {2'b10, e0}) begin
                n_fail++;
                $display("FAIL b2b_stall_%0d: valid=%b done=%b data=0x%016h, required 1 0 0x%016h",
                         c, if_b.sample_valid, if_b.done, if_b.sample_data, e0);
            end
        end
        if_b.sample_ready = 1'b1;
        tick();
        // W+2 = 4 cycles from the first handoff to the second.
        for (int c = 1; c <= 3; c++) begin
            n_tests++;
            if ({if_b.sample_valid, if_b.done, if_b.busy, if_b.accepted_count} !==
                {3'b001, 16'd1}) begin
                n_fail++;
                $display("FAIL b2b_gap_c%0d: valid/done/busy=%b%b%b acc=%0d, required 001 1", c,
                         if_b.sample_valid, if_b.done, if_b.busy, if_b.accepted_count);
            end
            tick();
        end
        n_tests++;
        if ({if_b.sample_valid, if_b.sample_data} !== {1'b1, e1}) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b data=0x%016h, required 1 0x%016h",
                     if_b.sample_valid, if_b.sample_data, e1);
        end
        tick();
        n_tests++;
        if ({if_b.sample_valid, if_b.done, if_b.busy, if_b.accepted_count} !== {3'b010, 16'd2}) begin
            n_fail++;
            $display("FAIL b2b_done: valid/done/busy=%b%b%b acc=%0d, required 010 2",
                     if_b.sample_valid, if_b.done, if_b.busy, if_b.accepted_count);
        end
        if_b.sample_ready = 1'b0;
        tick();
    endtask

    task automatic test_corners();
        do_reset();
        mode_a = 0;
        if_a.sample_ready = 1'b1;
        // Zero-length request.
        n_tests++;
        if (if_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_n_pre: busy=%b, required 0", if_a.busy);
        end
        start_a(16'd0);
        n_tests++;
        if ({if_a.sample_valid, if_a.done, if_a.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL zero_n_done: valid/done/busy=%b%b%b, required 010",
                     if_a.sample_valid, if_a.done, if_a.busy);
        end
        tick();
        n_tests++;
        if ({if_a.done, if_a.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_n_after: done/busy=%b%b, required 00", if_a.done, if_a.busy);
        end
        // Seed load in the start cycle feeds the first fill.
        model_rng = 32'hDEAD_BEEF;
        push_a();
        if_a.seed_load = 1'b1;
        if_a.seed_in   = 32'hDEAD_BEEF;
        start_a(16'd1);
        if_a.seed_load = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({if_a.sample_valid, if_a.sample_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL seed_start: valid=%b data=0x%08h, required 1 0xdeadbeef",
                     if_a.sample_valid, if_a.sample_data);
        end
        tick();
        tick();
        // Zero seed maps to 1.
        if_a.seed_load = 1'b1;
        if_a.seed_in   = 32'h0;
        tick();
        if_a.seed_load = 1'b0;
        model_rng = 32'h1;
        push_a();
        start_a(16'd1);
        tick();
        tick();
        n_tests++;
        if ({if_a.sample_valid, if_a.sample_data} !== {1'b1, 32'h0000_0001}) begin
            n_fail++;
            $display("FAIL seed_zero: valid=%b data=0x%08h, required 1 0x00000001",
                     if_a.sample_valid, if_a.sample_data);
        end
        tick();
        tick();
        // Start while busy is ignored: one sample, then done.
        if_a.sample_ready = 1'b0;
        push_a();
        start_a(16'd1);
        if_a.n_samples = 16'd5;
        if_a.start     = 1'b1;
        tick();
        tick();
        tick();
        if_a.start        = 1'b0;
        if_a.sample_ready = 1'b1;
        tick();
        n_tests++;
        if ({if_a.sample_valid, if_a.done, if_a.busy, if_a.accepted_count} !== {3'b010, 16'd1}) begin
            n_fail++;
            $display("FAIL busy_start: valid/done/busy=%b%b%b acc=%0d, required 010 1",
                     if_a.sample_valid, if_a.done, if_a.busy, if_a.accepted_count);
        end
        tick();
        // Reset in HOLD drops the sample with no done and restores the seed.
        if_a.sample_ready = 1'b0;
        start_a(16'd1);
        tick();
        tick();
        n_tests++;
        if (if_a.sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_pre: valid=%b, required 1", if_a.sample_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rng = 32'h1;
        n_tests++;
        if ({if_a.sample_valid, if_a.done, if_a.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_hold: valid/done/busy=%b%b%b, required 000",
                     if_a.sample_valid, if_a.done, if_a.busy);
        end
        tick();
        n_tests++;
        if (if_a.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold_done: done=%b, required 0", if_a.done);
        end
        if_a.sample_ready = 1'b1;
        push_a();
        start_a(16'd1);
        tick();
        tick();
        n_tests++;
        if ({if_a.sample_valid, if_a.sample_data} !== {1'b1, 32'h0000_0001}) begin
            n_fail++;
            $display("FAIL rst_reseed: valid=%b data=0x%08h, required 1 0x00000001",
                     if_a.sample_valid, if_a.sample_data);
        end
        tick();
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        mode_a = 0;
        if_a.start = 1'b0; if_a.n_samples = '0; if_a.seed_load = 1'b0; if_a.seed_in = '0;
        if_a.sample_ready = 1'b0;
        if_b.start = 1'b0; if_b.n_samples = '0; if_b.seed_load = 1'b0; if_b.seed_in = '0;
        if_b.sample_ready = 1'b0;
        model_rng = 32'h1;

        test_reset();
        test_one_word();
        test_reject();
        test_timeout();
        test_back_to_back();
        test_corners();

        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d samples never handed off, required 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
